luma_dequant_recon: RTL

LUMA_DEQUANT_RECON -- requirements
Module: luma_dequant_recon

---
 rtl/luma_dequant_recon.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/luma_dequant_recon.sv
// Luma macroblock reconstruction: dequantise levels, inverse WHT of DCs,
// per-block inverse DCT, add prediction and clip into Yout.
module luma_dequant_recon #(
  parameter int BLOCK_SIZE = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]   YPred,
  input  logic [255:0]                         Y_dc_levels,
  input  logic [4095:0]                        Y_ac_levels,
  input  logic [255:0]                         q1,
  input  logic [255:0]                         q2,
  output logic [8*BLOCK_SIZE*BLOCK_SIZE-1:0]   Yout,
  output logic                                 busy,
  output logic                                 done
);

  localparam int PW = 8 * BLOCK_SIZE * BLOCK_SIZE;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DEQ  = 3'd1;
  localparam logic [2:0] S_WHT  = 3'd2;
  localparam logic [2:0] S_IDCT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [3:0]         blk_q, blk_d;
  logic [PW-1:0]      pred_q, yout_q;
  logic signed [15:0] dcl_q  [16];
  logic signed [15:0] acl_q  [16][16];
  logic [15:0]        q1_q   [16];
  logic [15:0]        q2_q   [16];
  logic signed [15:0] dcc_q  [16];
  logic signed [15:0] coef_q [16][16];

  logic signed [23:0] wt [16];
  logic signed [23:0] ws [16];
  logic signed [23:0] w0, w1, w2, w3, wdc;

  logic signed [31:0] ic [16];
  logic signed [31:0] vt [16];
  logic signed [31:0] rs [16];
  logic signed [31:0] ia, ib, icc, idd, idc, sm;
  logic [10:0]        pbase [16];
  logic [7:0]         px [16];

  function automatic logic signed [15:0] sat_mul(
    input logic signed [15:0] l,
    input logic [15:0]        q
  );
    logic signed [32:0] p;
    p = 33'(l) * 33'($signed({1'b0, q}));
    if (p > 33'sd32767) return 16'sd32767;
    if (p < -33'sd32768) return -16'sd32768;
    return p[15:0];
  endfunction

  // x * (1 + 20091/65536), floor
  function automatic logic signed [31:0] mul1(
    input logic signed [31:0] x
  );
    logic signed [47:0] p;
    p = 48'(x) * 48'sd20091;
    return x + 32'(p >>> 16);
  endfunction

  // x * 35468/65536, floor
  function automatic logic signed [31:0] mul2(
    input logic signed [31:0] x
  );
    logic signed [47:0] p;
    p = 48'(x) * 48'sd35468;
    return 32'(p >>> 16);
  endfunction

  // Sequencer: IDLE -> DEQ -> WHT -> 16x IDCT -> DONE
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_DEQ;
      S_DEQ:  state_d = S_WHT;
      S_WHT: begin
        state_d = S_IDCT;
        blk_d   = '0;
      end
      S_IDCT: begin
        blk_d = blk_q + 4'd1;
        if (blk_q == 4'd15) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and block counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end
  end

  // Capture a full input snapshot on the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_q <= '0;
      for (int i = 0; i < 16; i++) begin
        dcl_q[i] <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        for (int k = 0; k < 16; k++) acl_q[i][k] <= '0;
      end
    end else if (state_q == S_IDLE && start) begin
      pred_q <= YPred;
      for (int i = 0; i < 16; i++) begin
        dcl_q[i] <= Y_dc_levels[16*i +: 16];
        q1_q[i]  <= q1[16*i +: 16];
        q2_q[i]  <= q2[16*i +: 16];
        for (int k = 0; k < 16; k++)
          acl_q[i][k] <= Y_ac_levels[16*(16*i+k) +: 16];
      end
    end
  end

  // Inverse WHT of the dequantised DC terms
  always_comb begin
    w0 = '0; w1 = '0; w2 = '0; w3 = '0; wdc = '0;
    for (int i = 0; i < 4; i++) begin
      w0 = 24'(dcc_q[i])   + 24'(dcc_q[12+i]);
      w1 = 24'(dcc_q[4+i]) + 24'(dcc_q[8+i]);
      w2 = 24'(dcc_q[4+i]) - 24'(dcc_q[8+i]);
      w3 = 24'(dcc_q[i])   - 24'(dcc_q[12+i]);
      wt[i]    = w0 + w1;
      wt[8+i]  = w0 - w1;
      wt[4+i]  = w3 + w2;
      wt[12+i] = w3 - w2;
    end
    for (int i = 0; i < 4; i++) begin
      wdc = wt[4*i] + 24'sd3;
      w0  = wdc + wt[4*i+3];
      w1  = wt[4*i+1] + wt[4*i+2];
      w2  = wt[4*i+1] - wt[4*i+2];
      w3  = wdc - wt[4*i+3];
      ws[4*i]   = (w0 + w1) >>> 3;
      ws[4*i+1] = (w3 + w2) >>> 3;
      ws[4*i+2] = (w0 - w1) >>> 3;
      ws[4*i+3] = (w3 - w2) >>> 3;
    end
  end

  // Coefficients: dequantise in DEQ, insert WHT DCs in WHT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 16; b++) begin
        dcc_q[b] <= '0;
        for (int k = 0; k < 16; k++) coef_q[b][k] <= '0;
      end
    end else if (state_q == S_DEQ) begin
      for (int b = 0; b < 16; b++) begin
        dcc_q[b]     <= sat_mul(dcl_q[b], q2_q[b]);
        coef_q[b][0] <= '0;
        for (int k = 1; k < 16; k++)
          coef_q[b][k] <= sat_mul(acl_q[b][k], q1_q[k]);
      end
    end else if (state_q == S_WHT) begin
      for (int b = 0; b < 16; b++)
        coef_q[b][0] <= ws[b][15:0];
    end
  end

  // Inverse DCT of block blk_q plus prediction, clipped
  always_comb begin
    ia = '0; ib = '0; icc = '0; idd = '0; idc = '0; sm = '0;
    for (int k = 0; k < 16; k++) ic[k] = 32'(coef_q[blk_q][k]);
    for (int c = 0; c < 4; c++) begin
      ia  = ic[c] + ic[8+c];
      ib  = ic[c] - ic[8+c];
      icc = mul2(ic[4+c]) - mul1(ic[12+c]);
      idd = mul1(ic[4+c]) + mul2(ic[12+c]);
      vt[4*c]   = ia + idd;
      vt[4*c+1] = ib + icc;
      vt[4*c+2] = ib - icc;
      vt[4*c+3] = ia - idd;
    end
    for (int r = 0; r < 4; r++) begin
      idc = vt[r] + 32'sd4;
      ia  = idc + vt[8+r];
      ib  = idc - vt[8+r];
      icc = mul2(vt[4+r]) - mul1(vt[12+r]);
      idd = mul1(vt[4+r]) + mul2(vt[12+r]);
      rs[4*r]   = (ia + idd) >>> 3;
      rs[4*r+1] = (ib + icc) >>> 3;
      rs[4*r+2] = (ib - icc) >>> 3;
      rs[4*r+3] = (ia - idd) >>> 3;
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        pbase[4*r+c] = {blk_q[3:2], 2'(r), blk_q[1:0], 2'(c), 3'b000};
        sm = $signed({24'd0, pred_q[pbase[4*r+c] +: 8]}) + rs[4*r+c];
        if (sm < 0)        px[4*r+c] = 8'd0;
        else if (sm > 255) px[4*r+c] = 8'd255;
        else               px[4*r+c] = sm[7:0];
      end
    end
  end

  // Write one reconstructed 4x4 block per IDCT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yout_q <= '0;
    end else if (state_q == S_IDCT) begin
      for (int k = 0; k < 16; k++) yout_q[pbase[k] +: 8] <= px[k];
    end
  end

  assign Yout = yout_q;
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule
